// File: rtl/arp_rx_parser.sv
// Receive-side ARP request parser: validates an Ethernet/ARP header byte by byte and
// latches the requester's SHA/SPA for the reply transmitter when a request targets my_ip.
module arp_rx_parser (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_first,
  input  logic        rx_last,
  input  logic        tx_busy,
  input  logic [47:0] my_mac,
  input  logic [31:0] my_ip,
  output logic        send_mac,
  output logic [47:0] source_mac,
  output logic [31:0] source_ip,
  output logic [15:0] req_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, DISCARD, EMIT} state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        bc_ok_q, bc_ok_d, uc_ok_q, uc_ok_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic [47:0] source_mac_q;
  logic [31:0] source_ip_q;
  logic [15:0] req_cnt_q, drop_cnt_q;
  logic        send_q;

  logic        start, active, byte_ok, dst_byte, fixed_chk;
  logic        accept, drop;
  logic [5:0]  cur_idx;
  logic [7:0]  exp_byte, mac_byte;

  // A first-byte strobe always restarts the frame, whatever state we are in.
  assign start   = rx_valid & rx_first;
  assign active  = rx_valid & (start | (state_q == CHECK));
  assign cur_idx = start ? 6'd0 : idx_q;

  always_comb begin
    exp_byte  = 8'h00;
    mac_byte  = 8'h00;
    dst_byte  = 1'b0;
    fixed_chk = 1'b1;
    case (cur_idx)
      6'd0:  begin dst_byte = 1'b1; mac_byte = my_mac[47:40]; end
      6'd1:  begin dst_byte = 1'b1; mac_byte = my_mac[39:32]; end
      6'd2:  begin dst_byte = 1'b1; mac_byte = my_mac[31:24]; end
      6'd3:  begin dst_byte = 1'b1; mac_byte = my_mac[23:16]; end
      6'd4:  begin dst_byte = 1'b1; mac_byte = my_mac[15:8];  end
      6'd5:  begin dst_byte = 1'b1; mac_byte = my_mac[7:0];   end
      6'd12: exp_byte = 8'h08;
      6'd13: exp_byte = 8'h06;
      6'd14: exp_byte = 8'h00;
      6'd15: exp_byte = 8'h01;
      6'd16: exp_byte = 8'h08;
      6'd17: exp_byte = 8'h00;
      6'd18: exp_byte = 8'h06;
      6'd19: exp_byte = 8'h04;
      6'd20: exp_byte = 8'h00;
      6'd21: exp_byte = 8'h01;
      6'd38: exp_byte = my_ip[31:24];
      6'd39: exp_byte = my_ip[23:16];
      6'd40: exp_byte = my_ip[15:8];
      6'd41: exp_byte = my_ip[7:0];
      default: fixed_chk = 1'b0;
    endcase
  end

  // Broadcast and unicast destination matches are tracked independently so a
  // mix of FF and my_mac bytes fails both.
  always_comb begin
    bc_ok_d = bc_ok_q;
    uc_ok_d = uc_ok_q;
    byte_ok = 1'b1;
    if (dst_byte) begin
      bc_ok_d = (start | bc_ok_q) & (rx_data == 8'hFF);
      uc_ok_d = (start | uc_ok_q) & (rx_data == mac_byte);
      byte_ok = bc_ok_d | uc_ok_d;
    end else if (fixed_chk) begin
      byte_ok = (rx_data == exp_byte);
    end
    if (!active) begin
      bc_ok_d = bc_ok_q;
      uc_ok_d = uc_ok_q;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (active) begin
      if (rx_last) begin
        if (!start && byte_ok && (cur_idx >= 6'd41)) state_d = EMIT;
        else                                          state_d = IDLE;
      end else if (!byte_ok) begin
        state_d = DISCARD;
      end else begin
        state_d = CHECK;
      end
    end else begin
      case (state_q)
        DISCARD: if (rx_valid && rx_last) state_d = IDLE;
        EMIT:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    accept = (state_d == EMIT) & ~tx_busy;
    drop   = (state_d == EMIT) &  tx_busy;
  end

  always_comb begin
    idx_d = idx_q;
    if (rx_valid) begin
      if (start)               idx_d = 6'd1;
      else if (idx_q != 6'd63) idx_d = idx_q + 6'd1;
    end
    sha_d = sha_q;
    spa_d = spa_q;
    if (active && (cur_idx >= 6'd22) && (cur_idx <= 6'd27)) sha_d = {sha_q[39:0], rx_data};
    if (active && (cur_idx >= 6'd28) && (cur_idx <= 6'd31)) spa_d = {spa_q[23:0], rx_data};
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      idx_q        <= 6'd0;
      bc_ok_q      <= 1'b0;
      uc_ok_q      <= 1'b0;
      sha_q        <= 48'd0;
      spa_q        <= 32'd0;
      source_mac_q <= 48'd0;
      source_ip_q  <= 32'd0;
      req_cnt_q    <= 16'd0;
      drop_cnt_q   <= 16'd0;
      send_q       <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      bc_ok_q <= bc_ok_d;
      uc_ok_q <= uc_ok_d;
      sha_q   <= sha_d;
      spa_q   <= spa_d;
      send_q  <= accept;
      if (accept) begin
        source_mac_q <= sha_q;
        source_ip_q  <= spa_q;
        if (req_cnt_q != 16'hFFFF) req_cnt_q <= req_cnt_q + 16'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign send_mac   = send_q;
  assign source_mac = source_mac_q;
  assign source_ip  = source_ip_q;
  assign req_cnt    = req_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Directed bench for arp_rx_parser: a vector table of whole frames plus hand sequences
// for truncation, mid-frame restart, back-to-back frames and asynchronous reset.
module tb_arp_rx_parser;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_first = 1'b0;
  logic        rx_last = 1'b0;
  logic        tx_busy = 1'b0;
  logic [47:0] my_mac = 48'h020000000001;
  logic [31:0] my_ip = 32'hC0A8010A;
  logic        send_mac;
  logic [47:0] source_mac;
  logic [31:0] source_ip;
  logic [15:0] req_cnt;
  logic [15:0] drop_cnt;

  arp_rx_parser dut (
    .clk(clk), .areset_n(areset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_first(rx_first), .rx_last(rx_last), .tx_busy(tx_busy),
    .my_mac(my_mac), .my_ip(my_ip), .send_mac(send_mac),
    .source_mac(source_mac), .source_ip(source_ip),
    .req_cnt(req_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  logic [7:0] fb [64];

  always @(posedge clk) if (send_mac === 1'b1) pulse_cnt <= pulse_cnt + 1;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] oper;
    logic [31:0] tpa;
    logic [47:0] sha;
    logic [31:0] spa;
    logic        busy;
    int          len;
    int          bad_idx;
    logic [7:0]  bad_val;
    int          gap_pct;
    logic        exp_pulse;
    logic [47:0] exp_mac;
    logic [31:0] exp_ip;
    logic [15:0] exp_req;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] oper, input logic [31:0] tpa,
                       input logic [47:0] sha, input logic [31:0] spa);
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]      = dst[47-8*i -: 8];
      fb[6+i]    = sha[47-8*i -: 8];
      fb[22+i]   = sha[47-8*i -: 8];
    end
    fb[12] = 8'h08; fb[13] = 8'h06; fb[14] = 8'h00; fb[15] = 8'h01;
    fb[16] = 8'h08; fb[17] = 8'h00; fb[18] = 8'h06; fb[19] = 8'h04;
    fb[20] = oper[15:8]; fb[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      fb[28+i] = spa[31-8*i -: 8];
      fb[38+i] = tpa[31-8*i -: 8];
    end
  endtask

  // tx_busy is held opposite to its final value until the last byte to show it is
  // only sampled in the rx_last cycle.
  task automatic send_bytes(input int from, input int to, input bit use_first, input bit use_last,
                            input bit busy, input int gap_pct);
    for (int i = from; i <= to; i++) begin
      int g;
      g = 0;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct && g < 3) begin
        rx_valid = 1'b0;
        rx_first = 1'($urandom_range(1));
        rx_last  = 1'($urandom_range(1));
        rx_data  = 8'($urandom);
        @(posedge clk); #1;
        g++;
      end
      rx_valid = 1'b1;
      rx_data  = fb[i];
      rx_first = use_first && (i == from);
      rx_last  = use_last && (i == to);
      tx_busy  = (i == to) ? busy : ~busy;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; rx_first = 1'b0; rx_last = 1'b0; tx_busy = 1'b0;
  endtask

  initial begin
    int p0;
    vecs[0]  = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'hAABBCCDDEEFF, 32'hC0A80105, 1'b0, 60, -1, 8'h00, 0,  1'b1, 48'hAABBCCDDEEFF, 32'hC0A80105, 16'd1, 16'd0};
    vecs[1]  = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010B, 48'h112233445566, 32'hC0A80107, 1'b0, 60, -1, 8'h00, 0,  1'b0, 48'hAABBCCDDEEFF, 32'hC0A80105, 16'd1, 16'd0};
    vecs[2]  = '{48'hFFFFFFFFFFFF, 16'h0002, 32'hC0A8010A, 48'h112233445566, 32'hC0A80107, 1'b0, 60, -1, 8'h00, 0,  1'b0, 48'hAABBCCDDEEFF, 32'hC0A80105, 16'd1, 16'd0};
    vecs[3]  = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'h112233445566, 32'hC0A80107, 1'b0, 60, 13, 8'h00, 0,  1'b0, 48'hAABBCCDDEEFF, 32'hC0A80105, 16'd1, 16'd0};
    vecs[4]  = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'h112233445566, 32'hC0A80107, 1'b1, 60, -1, 8'h00, 0,  1'b0, 48'hAABBCCDDEEFF, 32'hC0A80105, 16'd1, 16'd1};
    vecs[5]  = '{48'h020000000001, 16'h0001, 32'hC0A8010A, 48'h112233445566, 32'hC0A80107, 1'b0, 60, -1, 8'h00, 30, 1'b1, 48'h112233445566, 32'hC0A80107, 16'd2, 16'd1};
    vecs[6]  = '{48'h020000000002, 16'h0001, 32'hC0A8010A, 48'hA1A2A3A4A5A6, 32'hC0A80108, 1'b0, 60, -1, 8'h00, 0,  1'b0, 48'h112233445566, 32'hC0A80107, 16'd2, 16'd1};
    vecs[7]  = '{48'hFF0000000001, 16'h0001, 32'hC0A8010A, 48'hA1A2A3A4A5A6, 32'hC0A80108, 1'b0, 60, -1, 8'h00, 0,  1'b0, 48'h112233445566, 32'hC0A80107, 16'd2, 16'd1};
    vecs[8]  = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'hA1A2A3A4A5A6, 32'hC0A80108, 1'b0, 60, 19, 8'h06, 0,  1'b0, 48'h112233445566, 32'hC0A80107, 16'd2, 16'd1};
    vecs[9]  = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'h0A0B0C0D0E0F, 32'hC0A80163, 1'b0, 60, 50, 8'hAB, 0,  1'b1, 48'h0A0B0C0D0E0F, 32'hC0A80163, 16'd3, 16'd1};
    vecs[10] = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'hB1B2B3B4B5B6, 32'hC0A80164, 1'b0, 41, -1, 8'h00, 0,  1'b0, 48'h0A0B0C0D0E0F, 32'hC0A80163, 16'd3, 16'd1};
    vecs[11] = '{48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'hC1C2C3C4C5C6, 32'hC0A80165, 1'b0, 42, -1, 8'h00, 0,  1'b1, 48'hC1C2C3C4C5C6, 32'hC0A80165, 16'd4, 16'd1};

    #12;
    chk("reset_send", {63'd0, send_mac}, 64'd0);
    chk("reset_mac", {16'd0, source_mac}, 64'd0);
    chk("reset_ip", {32'd0, source_ip}, 64'd0);
    chk("reset_cnts", {32'd0, req_cnt, drop_cnt}, 64'd0);
    @(posedge clk); #1;
    areset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 12; v++) begin
      build(vecs[v].dst, vecs[v].oper, vecs[v].tpa, vecs[v].sha, vecs[v].spa);
      if (vecs[v].bad_idx >= 0) fb[vecs[v].bad_idx] = vecs[v].bad_val;
      p0 = pulse_cnt;
      send_bytes(0, vecs[v].len - 1, 1'b1, 1'b1, vecs[v].busy, vecs[v].gap_pct);
      chk($sformatf("v%0d_pulse_edge", v), {63'd0, send_mac}, {63'd0, vecs[v].exp_pulse});
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_end", v), {63'd0, send_mac}, 64'd0);
      chk($sformatf("v%0d_pulse_count", v), 64'(pulse_cnt - p0), {63'd0, vecs[v].exp_pulse});
      chk($sformatf("v%0d_mac", v), {16'd0, source_mac}, {16'd0, vecs[v].exp_mac});
      chk($sformatf("v%0d_ip", v), {32'd0, source_ip}, {32'd0, vecs[v].exp_ip});
      chk($sformatf("v%0d_cnts", v), {32'd0, req_cnt, drop_cnt}, {32'd0, vecs[v].exp_req, vecs[v].exp_drop});
      $display("vec %0d: pulses=%0d mac=%h ip=%h req=%0d drop=%0d", v, pulse_cnt - p0, source_mac, source_ip, req_cnt, drop_cnt);
    end

    // Truncated frame, aborted frame, then a gappy valid request.
    build(48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'h665544332211, 32'hC0A80199);
    p0 = pulse_cnt;
    send_bytes(0, 30, 1'b1, 1'b1, 1'b0, 0);
    send_bytes(0, 19, 1'b1, 1'b0, 1'b0, 0);
    send_bytes(0, 59, 1'b1, 1'b1, 1'b0, 40);
    chk("restart_pulse_edge", {63'd0, send_mac}, 64'd1);
    @(posedge clk); #1;
    chk("restart_pulse_count", 64'(pulse_cnt - p0), 64'd1);
    chk("restart_mac", {16'd0, source_mac}, 64'h0000665544332211);
    chk("restart_ip", {32'd0, source_ip}, 64'h00000000C0A80199);
    chk("restart_req", {48'd0, req_cnt}, 64'd5);
    $display("restart seq: pulses=%0d mac=%h ip=%h req=%0d", pulse_cnt - p0, source_mac, source_ip, req_cnt);

    // Back-to-back: the second frame's first byte arrives in the EMIT cycle.
    p0 = pulse_cnt;
    build(48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'hD1D2D3D4D5D6, 32'hC0A80170);
    send_bytes(0, 59, 1'b1, 1'b1, 1'b0, 0);
    chk("b2b_first_pulse", {63'd0, send_mac}, 64'd1);
    chk("b2b_first_mac", {16'd0, source_mac}, 64'h0000D1D2D3D4D5D6);
    build(48'h020000000001, 16'h0001, 32'hC0A8010A, 48'hE1E2E3E4E5E6, 32'hC0A80171);
    send_bytes(0, 59, 1'b1, 1'b1, 1'b0, 0);
    chk("b2b_second_pulse", {63'd0, send_mac}, 64'd1);
    @(posedge clk); #1;
    chk("b2b_pulse_count", 64'(pulse_cnt - p0), 64'd2);
    chk("b2b_mac", {16'd0, source_mac}, 64'h0000E1E2E3E4E5E6);
    chk("b2b_req", {48'd0, req_cnt}, 64'd7);
    $display("b2b seq: pulses=%0d mac=%h ip=%h req=%0d", pulse_cnt - p0, source_mac, source_ip, req_cnt);

    // Asynchronous reset in the middle of a valid frame.
    p0 = pulse_cnt;
    build(48'hFFFFFFFFFFFF, 16'h0001, 32'hC0A8010A, 48'h123456789ABC, 32'hC0A80180);
    send_bytes(0, 25, 1'b1, 1'b0, 1'b0, 0);
    #2 areset_n = 1'b0;
    #1;
    chk("async_rst_mac", {16'd0, source_mac}, 64'd0);
    chk("async_rst_ip", {32'd0, source_ip}, 64'd0);
    chk("async_rst_cnts", {32'd0, req_cnt, drop_cnt}, 64'd0);
    @(posedge clk); #1;
    areset_n = 1'b1;
    send_bytes(26, 59, 1'b0, 1'b1, 1'b0, 0);
    chk("post_rst_no_pulse", {63'd0, send_mac}, 64'd0);
    @(posedge clk); #1;
    chk("post_rst_pulse_count", 64'(pulse_cnt - p0), 64'd0);
    chk("post_rst_outputs", {source_mac, 16'd0} | {32'd0, source_ip} | {32'd0, req_cnt, drop_cnt}, 64'd0);
    send_bytes(0, 59, 1'b1, 1'b1, 1'b0, 0);
    chk("post_rst_accept_pulse", {63'd0, send_mac}, 64'd1);
    @(posedge clk); #1;
    chk("post_rst_mac", {16'd0, source_mac}, 64'h0000123456789ABC);
    chk("post_rst_ip", {32'd0, source_ip}, 64'h00000000C0A80180);
    chk("post_rst_cnts", {32'd0, req_cnt, drop_cnt}, {32'd0, 16'd1, 16'd0});
    $display("reset seq: pulses=%0d mac=%h ip=%h req=%0d drop=%0d", pulse_cnt - p0, source_mac, source_ip, req_cnt, drop_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
